// File: rtl/inference_sequencer_pkg.sv
// Shared definitions for the inference sequencer: default sizing, the
// derived image beat count, sequencer state encodings and the soft-reset
// (prst) encodings driven towards class_top.
package inference_sequencer_pkg;

  localparam int CLAUSEN_D = 140;
  localparam int CLASSN_D  = 10;
  localparam int HEIGHT_D  = 28;
  localparam int WIDTH_D   = 28;
  localparam int BEAT_W_D  = 512;
  localparam int TIMEOUT_D = 4095;

  // Number of image beats needed to carry HEIGHT*WIDTH pixels
  function automatic int beats_of(input int height, input int width, input int beat_w);
    return (height * width + beat_w - 1) / beat_w;
  endfunction

  localparam int BEATS_D = beats_of(HEIGHT_D, WIDTH_D, BEAT_W_D);

  // SRST holds the soft reset for this many cycles
  localparam int SRST_CYCLES = 2;

  // prst = {img_rst, rst}
  localparam logic [1:0] P_RUN  = 2'b00;
  localparam logic [1:0] P_SRST = 2'b01;
  localparam logic [1:0] P_IRST = 2'b10;

  // S_ABRT is the single img_rst cycle issued after a compute timeout
  typedef enum logic [3:0] {
    S_IDLE,
    S_SRST,
    S_LDC,
    S_LDW,
    S_IRST,
    S_STRM,
    S_CMP,
    S_RES,
    S_ABRT
  } seq_state_t;

endpackage

// File: rtl/inference_sequencer_if.sv
// Host/datapath bus of the inference sequencer. The master modport is the
// sequencer side; the slave modport is the host/DMA plus class_top side.
interface inference_sequencer_if
  import inference_sequencer_pkg::*;
#(
  parameter int CA_W = $clog2(CLAUSEN_D),
  parameter int WA_W = $clog2(CLASSN_D),
  parameter int BI_W = $clog2(BEATS_D + 1)
);

  logic [8:0]      cfg_clauses;
  logic [3:0]      cfg_classes;
  logic            start_load;
  logic            start_img;
  logic [CA_W-1:0] clause_addr;
  logic [WA_W-1:0] weight_addr;
  logic            load_strobe;
  logic [1:0]      prst;
  logic [BI_W-1:0] beat_idx;
  logic            dp_tvalid;
  logic            dp_tready;
  logic [4:0]      dp_params;
  logic            res_valid;
  logic            res_ready;
  logic [3:0]      res_class;
  logic            model_ready;
  logic            busy;
  logic            err_timeout;

  modport master (
    input  cfg_clauses, cfg_classes, start_load, start_img,
    input  dp_tready, dp_params, res_ready,
    output clause_addr, weight_addr, load_strobe, prst, beat_idx,
    output dp_tvalid, res_valid, res_class, model_ready, busy, err_timeout
  );

  modport slave (
    output cfg_clauses, cfg_classes, start_load, start_img,
    output dp_tready, dp_params, res_ready,
    input  clause_addr, weight_addr, load_strobe, prst, beat_idx,
    input  dp_tvalid, res_valid, res_class, model_ready, busy, err_timeout
  );

endinterface

// File: rtl/inference_sequencer_seq_timer.sv
// seq_timer: loadable up-counter with a terminal flag. Used for the
// soft-reset hold and for the compute timeout.
module seq_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] count;

  // Restart from zero on load, otherwise count while enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign done = (count == term);

endmodule

// File: rtl/inference_sequencer.sv
// inference_sequencer: control sequencer for the class_top TM datapath.
// Loads the model (clause then weight address sweep), streams one image,
// waits for done and returns the class over a valid/ready port.
// Optional feature macro: CYCLE_COUNT_EN adds res_cycles, the number of
// cycles from stream entry to done capture (saturating).
module inference_sequencer
  import inference_sequencer_pkg::*;
#(
  parameter int CLAUSEN = CLAUSEN_D,
  parameter int CLASSN  = CLASSN_D,
  parameter int HEIGHT  = HEIGHT_D,
  parameter int WIDTH   = WIDTH_D,
  parameter int BEAT_W  = BEAT_W_D,
  parameter int TIMEOUT = TIMEOUT_D
) (
  input  logic                  clk,
  input  logic                  rst,
  inference_sequencer_if.master bus
`ifdef CYCLE_COUNT_EN
  ,
  output logic [15:0]           res_cycles
`endif
);

  localparam int BEATS = beats_of(HEIGHT, WIDTH, BEAT_W);
  localparam int CA_W  = $clog2(CLAUSEN);
  localparam int WA_W  = $clog2(CLASSN);
  localparam int BI_W  = $clog2(BEATS + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);

  seq_state_t      state, state_next;
  logic [CA_W-1:0] clause_addr;
  logic [WA_W-1:0] weight_addr;
  logic [8:0]      n_clauses;
  logic [3:0]      n_classes;
  logic            model_ready;
  logic [BI_W-1:0] beat_idx;
  logic [3:0]      res_class;
  logic            res_valid;
  logic            err_timeout;

  logic            load_strobe;
  logic            dp_tvalid;
  logic [1:0]      prst;
  logic            tmr_load;
  logic            tmr_en;
  logic [TW-1:0]   tmr_term;
  logic            tmr_done;
  logic [8:0]      clauses_clamped;
  logic [3:0]      classes_clamped;
  logic            last_clause;
  logic            last_weight;

  // Zero counts are treated as one so a sweep never wraps the address
  assign clauses_clamped = (bus.cfg_clauses == 9'd0) ? 9'd1 :
                           (bus.cfg_clauses > 9'(CLAUSEN)) ? 9'(CLAUSEN) : bus.cfg_clauses;
  assign classes_clamped = (bus.cfg_classes == 4'd0) ? 4'd1 :
                           (bus.cfg_classes > 4'(CLASSN)) ? 4'(CLASSN) : bus.cfg_classes;

  assign last_clause = (9'(clause_addr) == (n_clauses - 9'd1));
  assign last_weight = (4'(weight_addr) == (n_classes - 4'd1));

  seq_timer #(.W(TW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .en   (tmr_en),
    .term (tmr_term),
    .done (tmr_done)
  );

  assign tmr_en = (state == S_SRST) || (state == S_CMP);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state and state-decoded outputs; the timer restarts on every state change
  always_comb begin
    state_next  = state;
    load_strobe = 1'b0;
    dp_tvalid   = 1'b0;
    prst        = P_RUN;
    tmr_term    = TW'(SRST_CYCLES - 1);
    case (state)
      S_IDLE: begin
        prst = {1'b0, !model_ready};
        if (bus.start_load)                    state_next = S_SRST;
        else if (bus.start_img && model_ready) state_next = S_IRST;
      end
      S_SRST: begin
        prst = P_SRST;
        if (tmr_done) state_next = S_LDC;
      end
      S_LDC: begin
        load_strobe = 1'b1;
        if (last_clause) state_next = S_LDW;
      end
      S_LDW: begin
        load_strobe = 1'b1;
        if (last_weight) state_next = S_IDLE;
      end
      S_IRST: begin
        prst       = P_IRST;
        state_next = S_STRM;
      end
      S_STRM: begin
        dp_tvalid = (beat_idx < BI_W'(BEATS));
        if (beat_idx == BI_W'(BEATS)) state_next = S_CMP;
      end
      S_CMP: begin
        tmr_term = TW'(TIMEOUT - 1);
        if (bus.dp_params[4]) state_next = S_RES;
        else if (tmr_done)    state_next = S_ABRT;
      end
      S_RES: begin
        if (bus.res_ready) state_next = S_IDLE;
      end
      S_ABRT: begin
        prst       = P_IRST;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    tmr_load = (state_next != state);
  end

  // Address sweeps, load/beat bookkeeping and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clause_addr <= '1;
      weight_addr <= '1;
      n_clauses   <= 9'd1;
      n_classes   <= 4'd1;
      model_ready <= 1'b0;
      beat_idx    <= '0;
      res_class   <= 4'd0;
      res_valid   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_load) begin
            n_clauses   <= clauses_clamped;
            n_classes   <= classes_clamped;
            model_ready <= 1'b0;
          end
        end
        S_SRST: begin
          if (tmr_done) clause_addr <= '0;
        end
        S_LDC: begin
          if (last_clause) begin
            clause_addr <= '1;
            weight_addr <= '0;
          end else begin
            clause_addr <= clause_addr + CA_W'(1);
          end
        end
        S_LDW: begin
          if (last_weight) begin
            weight_addr <= '1;
            model_ready <= 1'b1;
          end else begin
            weight_addr <= weight_addr + WA_W'(1);
          end
        end
        S_IRST: begin
          beat_idx    <= '0;
          res_class   <= 4'd0;
          err_timeout <= 1'b0;
        end
        S_STRM: begin
          if (dp_tvalid && bus.dp_tready) beat_idx <= beat_idx + BI_W'(1);
        end
        S_CMP: begin
          if (bus.dp_params[4]) begin
            res_class <= bus.dp_params[3:0];
            res_valid <= 1'b1;
          end else if (tmr_done) begin
            err_timeout <= 1'b1;
          end
        end
        S_RES: begin
          if (bus.res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef CYCLE_COUNT_EN
  logic [15:0] cyc_cnt;

  // Saturating stream-to-done cycle counter, latched at done capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt    <= 16'd0;
      res_cycles <= 16'd0;
    end else begin
      if (state == S_IRST) begin
        cyc_cnt <= 16'd0;
      end else if ((state == S_STRM || state == S_CMP) && cyc_cnt != 16'hFFFF) begin
        cyc_cnt <= cyc_cnt + 16'd1;
      end
      if (state == S_CMP && bus.dp_params[4]) res_cycles <= cyc_cnt;
    end
  end
`endif

  assign bus.clause_addr = clause_addr;
  assign bus.weight_addr = weight_addr;
  assign bus.load_strobe = load_strobe;
  assign bus.prst        = prst;
  assign bus.beat_idx    = beat_idx;
  assign bus.dp_tvalid   = dp_tvalid;
  assign bus.res_valid   = res_valid;
  assign bus.res_class   = res_class;
  assign bus.model_ready = model_ready;
  assign bus.busy        = (state != S_IDLE);
  assign bus.err_timeout = err_timeout;

endmodule

// File: tb/tb_inference_sequencer.sv
// Testbench for inference_sequencer: scoreboard queues for clause/weight
// addresses and result classes, a small class_top model for the stream side.
module tb_inference_sequencer;
  import inference_sequencer_pkg::*;

  localparam int TIMEOUT = TIMEOUT_D;
  localparam int BEATS   = BEATS_D;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inference_sequencer_if bus ();
`ifdef CYCLE_COUNT_EN
  logic [15:0] res_cycles;
`endif

  inference_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CYCLE_COUNT_EN
    ,
    .res_cycles (res_cycles)
`endif
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int clause_q[$];
  int weight_q[$];
  int res_q[$];

  int strobe_total = 0;
  int beat_total   = 0;
  int beat_base    = 0;
  int prst10_total = 0;
  int post_total   = 0;
  int res_hs_total = 0;

  bit dp_active  = 1'b0;
  bit early_done = 1'b0;
  bit done_en    = 1'b0;
  int done_delay = 0;
  int done_cls   = 0;
  int post_dp    = 0;

  // Monitor: pops scoreboards and counts events on the falling edge
  always @(negedge clk) begin
    int e;
    if (rst !== 1'b1) begin
      if (bus.prst == 2'b10) prst10_total++;
      if (bus.busy && bus.prst == 2'b00 && !bus.dp_tvalid && (beat_total - beat_base) == BEATS)
        post_total++;
      if (bus.load_strobe) begin
        strobe_total++;
        if (bus.clause_addr != 8'hFF) begin
          if (clause_q.size() > 0) begin
            e = clause_q.pop_front();
            check("clause_addr", 32'(bus.clause_addr), e);
          end else begin
            check("clause_extra", 32'(bus.clause_addr), 32'hFF);
          end
        end else if (bus.weight_addr != 4'hF) begin
          if (weight_q.size() > 0) begin
            e = weight_q.pop_front();
            check("weight_addr", 32'(bus.weight_addr), e);
          end else begin
            check("weight_extra", 32'(bus.weight_addr), 32'hF);
          end
        end
      end
      if (bus.dp_tvalid && bus.dp_tready) begin
        check("beat_idx", 32'(bus.beat_idx), beat_total - beat_base);
        beat_total++;
      end
      if (bus.res_valid && bus.res_ready) begin
        res_hs_total++;
        if (res_q.size() > 0) begin
          e = res_q.pop_front();
          check("res_class", 32'(bus.res_class), e);
          $display("result class=%0d expected=%0d", bus.res_class, e);
        end else begin
          check("res_unexpected", 32'(bus.res_valid), 0);
        end
      end
    end
  end

  // class_top model: toggling tready, optional early done during streaming,
  // done with the programmed class a fixed number of cycles after the stream
  always @(posedge clk) begin
    #1;
    if (!dp_active) begin
      bus.dp_tready = 1'b0;
      bus.dp_params = 5'd0;
      post_dp       = 0;
    end else begin
      bus.dp_tready = ~bus.dp_tready;
      if ((beat_total - beat_base) < BEATS) begin
        bus.dp_params = early_done ? {1'b1, 4'd3} : 5'd0;
      end else begin
        post_dp++;
        bus.dp_params = (done_en && post_dp >= done_delay) ? {1'b1, 4'(done_cls)} : 5'd0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int nc, input int nw, input int exp_c, input int exp_w, input bit with_img);
    int s0 = strobe_total;
    int b0 = beat_total;
    int p0 = prst10_total;
    for (int i = 0; i < exp_c; i++) clause_q.push_back(i);
    for (int i = 0; i < exp_w; i++) weight_q.push_back(i);
    tick();
    bus.cfg_clauses = 9'(nc);
    bus.cfg_classes = 4'(nw);
    bus.start_load  = 1'b1;
    bus.start_img   = with_img;
    tick();
    bus.start_load  = 1'b0;
    bus.start_img   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.model_ready && !bus.busy) break;
    end
    check("load_ready", 32'(bus.model_ready), 1);
    check("load_strobes", strobe_total - s0, exp_c + exp_w);
    check("clause_q_left", clause_q.size(), 0);
    check("weight_q_left", weight_q.size(), 0);
    check("idle_prst", 32'(bus.prst), 0);
    check("load_no_beats", beat_total - b0, 0);
    check("load_no_irst", prst10_total - p0, 0);
    $display("load cfg_clauses=%0d cfg_classes=%0d strobes=%0d", nc, nw, strobe_total - s0);
  endtask

  task automatic run_img(input int cls, input int delay, input bit done_on, input bit early, input int hold);
    int p0 = prst10_total;
    int r0 = res_hs_total;
    int s0 = strobe_total;
    int pb = post_total;
    tick();
    beat_base  = beat_total;
    done_cls   = cls;
    done_delay = delay;
    done_en    = done_on;
    early_done = early;
    dp_active  = 1'b1;
    if (done_on) res_q.push_back(cls);
    bus.res_ready = 1'b0;
    bus.start_img = 1'b1;
    tick();
    bus.start_img = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (bus.res_valid || !bus.busy) break;
    end
    check("beats", beat_total - beat_base, BEATS);
    if (done_on) begin
      check("res_valid", 32'(bus.res_valid), 1);
      for (int h = 0; h < hold; h++) begin
        if (h == 5) begin
          tick();
          bus.start_load = 1'b1;
          tick();
          bus.start_load = 1'b0;
        end
        @(negedge clk);
        check("hold_valid", 32'(bus.res_valid), 1);
        check("hold_class", 32'(bus.res_class), cls);
        check("hold_busy", 32'(bus.busy), 1);
      end
      tick();
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      @(negedge clk);
      check("res_drop", 32'(bus.res_valid), 0);
      check("res_idle", 32'(bus.busy), 0);
      check("res_handshakes", res_hs_total - r0, 1);
      check("irst_cycles", prst10_total - p0, 1);
      check("err_clear", 32'(bus.err_timeout), 0);
      check("model_kept", 32'(bus.model_ready), 1);
      check("no_strobes", strobe_total - s0, 0);
    end else begin
      check("to_idle", 32'(bus.busy), 0);
      check("to_err", 32'(bus.err_timeout), 1);
      check("to_cmp_cycles", post_total - pb, TIMEOUT + 1);
      check("to_no_result", res_hs_total - r0, 0);
      check("to_res_valid", 32'(bus.res_valid), 0);
      check("to_irst_cycles", prst10_total - p0, 2);
      $display("image timeout err_timeout=%0d", bus.err_timeout);
    end
    dp_active = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_seen;
    rst             = 1'b1;
    bus.cfg_clauses = 9'd0;
    bus.cfg_classes = 4'd0;
    bus.start_load  = 1'b0;
    bus.start_img   = 1'b0;
    bus.res_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_prst", 32'(bus.prst), 1);
    check("rst_clause_addr", 32'(bus.clause_addr), 'hFF);
    check("rst_weight_addr", 32'(bus.weight_addr), 'hF);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_res_valid", 32'(bus.res_valid), 0);
    check("rst_model_ready", 32'(bus.model_ready), 0);
    check("rst_load_strobe", 32'(bus.load_strobe), 0);
    check("rst_tvalid", 32'(bus.dp_tvalid), 0);
    tick();
    rst = 1'b0;

    // start_img before any model load must be ignored
    bus.start_img = 1'b1;
    tick();
    bus.start_img = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.busy) busy_seen++;
    end
    check("img_before_load", busy_seen, 0);

    do_load(3, 2, 3, 2, 1'b0);
    do_load(200, 15, 140, 10, 1'b0);
    do_load(140, 10, 140, 10, 1'b0);

    run_img(7, 900, 1'b1, 1'b1, 20);
    run_img(2, 5, 1'b1, 1'b0, 0);
    run_img(0, 0, 1'b0, 1'b0, 0);
    run_img(9, 30, 1'b1, 1'b0, 2);

    // Both starts together: load wins
    do_load(5, 3, 5, 3, 1'b1);

    // Asynchronous reset in the middle of streaming
    tick();
    beat_base  = beat_total;
    done_en    = 1'b0;
    early_done = 1'b0;
    dp_active  = 1'b1;
    bus.start_img = 1'b1;
    tick();
    bus.start_img = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.dp_tvalid) break;
    end
    check("t6_in_stream", 32'(bus.dp_tvalid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_busy", 32'(bus.busy), 0);
    @(negedge clk);
    check("t6_model_ready", 32'(bus.model_ready), 0);
    check("t6_prst", 32'(bus.prst), 1);
    check("t6_clause_addr", 32'(bus.clause_addr), 'hFF);
    check("t6_weight_addr", 32'(bus.weight_addr), 'hF);
    check("t6_tvalid", 32'(bus.dp_tvalid), 0);
    check("t6_beat_idx", 32'(bus.beat_idx), 0);
    dp_active = 1'b0;
    tick();
    rst = 1'b0;
    bus.start_img = 1'b1;
    tick();
    bus.start_img = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.busy) busy_seen++;
    end
    check("t6_img_ignored", busy_seen, 0);
    $display("reset mid-stream busy_cycles_after_start=%0d", busy_seen);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
